// File: rtl/ota_sched_pkg.sv
// Shared types and constants for the OTA share scheduler.
// Optional feature macro: OTA_SCHED_VOTE_EN selects 3-sample majority voting
// in SAMPLE instead of a single sample.
package ota_sched_pkg;

    // Sequencer states; every state except StIdle reports busy.
    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    // Number of comparator samples taken per transaction.
`ifdef OTA_SCHED_VOTE_EN
    localparam int unsigned VoteCnt = 3;
`else
    localparam int unsigned VoteCnt = 1;
`endif

    // Legal parameter ranges.
    localparam int unsigned NreqMin   = 2;
    localparam int unsigned NreqMax   = 8;
    localparam int unsigned SettleMin = 2;
    localparam int unsigned SettleMax = 255;

    // 2-of-3 majority.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/ota_share_sched_if.sv
// Bundle of request/ack and OTA control signals for the OTA share scheduler.
// master: requester/analog side (drives req and the raw comparator output).
// slave:  the scheduler (drives ack, result and the OTA controls).
interface ota_share_sched_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IdW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic            res_bit;
    logic [IdW-1:0]  res_id;
    logic [IdW-1:0]  mux_sel;
    logic            ota_en;
    logic            cmp_in;
    logic            busy;

    modport master (
        output req,
        output cmp_in,
        input  ack,
        input  res_bit,
        input  res_id,
        input  mux_sel,
        input  ota_en,
        input  busy
    );

    modport slave (
        input  req,
        input  cmp_in,
        output ack,
        output res_bit,
        output res_id,
        output mux_sel,
        output ota_en,
        output busy
    );

endinterface

// File: rtl/ota_rr_arb.sv
// Combinational round-robin pick: searches upward from i_ptr+1, wrapping
// modulo NREQ, and returns the first requester found.
module ota_rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IdW-1:0]  i_ptr,
    output logic            o_any,
    output logic [IdW-1:0]  o_g
);

    logic           w_found;
    logic [IdW-1:0] w_idx;

    // Scan all positions after the last winner; the last winner itself is checked last.
    always_comb begin
        o_any   = |i_req;
        o_g     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            w_idx = IdW'((int'(i_ptr) + k) % int'(NREQ));
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                o_g     = w_idx;
            end
        end
    end

endmodule

// File: rtl/ota_share_sched.sv
// Time-shares one OTA/comparator between NREQ requesters: round-robin grant,
// steer the input mux, enable the OTA for SETTLE_CYC cycles, sample the
// synchronised comparator and return a one-cycle ack with the result.
// Optional feature macro: OTA_SCHED_VOTE_EN (3-sample majority in SAMPLE).
module ota_share_sched
    import ota_sched_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned SETTLE_CYC = 8
) (
    input logic               clk,
    input logic               rst,
    ota_share_sched_if.slave  io_bus
);

    localparam int unsigned IdW  = $clog2(NREQ);
    localparam int unsigned CntW = ($clog2(SETTLE_CYC) > 0) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYC - 1);

    if ((NREQ < NreqMin) || (NREQ > NreqMax)) begin : g_bad_nreq
        $error("ota_share_sched: NREQ out of legal range");
    end
    if ((SETTLE_CYC < SettleMin) || (SETTLE_CYC > SettleMax)) begin : g_bad_settle
        $error("ota_share_sched: SETTLE_CYC out of legal range");
    end

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic [IdW-1:0]  r_ptr;
    logic [IdW-1:0]  r_mux_sel;
    logic [IdW-1:0]  r_res_id;
    logic [NREQ-1:0] r_ack;
    logic            r_res_bit;
    logic            r_ota_en;
    logic            r_cmp_meta;
    logic            r_cmp_s;

    logic            w_any;
    logic [IdW-1:0]  w_g;
    logic [NREQ-1:0] w_ack_onehot;
    logic            w_sample_last;
    logic            w_sample_bit;

    ota_rr_arb #(
        .NREQ (NREQ),
        .IdW  (IdW)
    ) u_arb (
        .i_req (io_bus.req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_g   (w_g)
    );

    assign w_ack_onehot = NREQ'(1) << r_mux_sel;

    // Two-flop synchroniser for the asynchronous comparator output, always clocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_meta <= 1'b0;
            r_cmp_s    <= 1'b0;
        end else begin
            r_cmp_meta <= io_bus.cmp_in;
            r_cmp_s    <= r_cmp_meta;
        end
    end

`ifdef OTA_SCHED_VOTE_EN
    logic [1:0] r_vidx;
    logic [1:0] r_votes;

    // Collect the earlier samples while in SAMPLE; the index restarts outside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vidx  <= '0;
            r_votes <= '0;
        end else if (r_state == StSample) begin
            r_vidx  <= r_vidx + 2'd1;
            r_votes <= {r_votes[0], r_cmp_s};
        end else begin
            r_vidx  <= '0;
        end
    end

    assign w_sample_last = (r_vidx == 2'(VoteCnt - 1));
    assign w_sample_bit  = maj3({r_votes, r_cmp_s});
`else
    assign w_sample_last = 1'b1;
    assign w_sample_bit  = r_cmp_s;
`endif

    // Sequencer: arbitrate, settle, sample, acknowledge; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_ptr     <= IdW'(NREQ - 1);
            r_mux_sel <= '0;
            r_res_id  <= '0;
            r_ack     <= '0;
            r_res_bit <= 1'b0;
            r_ota_en  <= 1'b0;
        end else begin
            r_ack <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_mux_sel <= w_g;
                        r_cnt     <= CntLoad;
                        r_ota_en  <= 1'b1;
                        r_state   <= StSettle;
                    end
                end
                StSettle: begin
                    if (r_cnt == '0) begin
                        r_state <= StSample;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StSample: begin
                    if (w_sample_last) begin
                        r_res_bit <= w_sample_bit;
                        r_res_id  <= r_mux_sel;
                        r_ack     <= w_ack_onehot;
                        r_ota_en  <= 1'b0;
                        r_state   <= StDone;
                    end
                end
                StDone: begin
                    // The winner just served drops to lowest priority.
                    r_ptr   <= r_mux_sel;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.ack     = r_ack;
    assign io_bus.res_bit = r_res_bit;
    assign io_bus.res_id  = r_res_id;
    assign io_bus.mux_sel = r_mux_sel;
    assign io_bus.ota_en  = r_ota_en;
    assign io_bus.busy    = (r_state != StIdle);

endmodule

// File: tb/tb_ota_share_sched.sv
// Scoreboard bench for ota_share_sched (NREQ=4, SETTLE_CYC=8).
// Honours OTA_SCHED_VOTE_EN for latency and vote expectations.
module tb_ota_share_sched;

    localparam int NREQ   = 4;
    localparam int SETTLE = 8;
`ifdef OTA_SCHED_VOTE_EN
    localparam int NVOTE    = 3;
    localparam int LATE_EXP = 0;
`else
    localparam int NVOTE    = 1;
    localparam int LATE_EXP = 1;
`endif
    localparam int LAT = SETTLE + 1 + NVOTE;
    localparam int GAP = LAT + 1;

    typedef struct {
        int   id;
        logic rb;
        int   at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   k;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ota_share_sched_if #(.NREQ(NREQ)) bus ();

    ota_share_sched #(
        .NREQ       (NREQ),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_exp(input int id, input logic rb, input int at);
        exp_t e;
        e.id = id;
        e.rb = rb;
        e.at = at;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for all expected acks, then let the DUT return to IDLE.
    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard: every ack pulse must match the oldest expected transaction.
    always @(negedge clk) begin
        if (!rst && bus.ack != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("ack_onehot", 32'(bus.ack), 32'd1 << mon_e.id);
                check_eq("res_id", 32'(bus.res_id), 32'(mon_e.id));
                check_eq("res_bit", 32'(bus.res_bit), 32'(mon_e.rb));
                check_eq("ack_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bus.req    = '0;
        bus.cmp_in = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ota_en", 32'(bus.ota_en), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ack", 32'(bus.ack), 32'd0);
        check_eq("rst_res_bit", 32'(bus.res_bit), 32'd0);
        check_eq("rst_res_id", 32'(bus.res_id), 32'd0);
        check_eq("rst_mux_sel", 32'(bus.mux_sel), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request, one-cycle pulse, timing window.
        bus.cmp_in = 1'b1;
        repeat (3) @(negedge clk);
        k = cyc;
        bus.req = 4'b0001;
        push_exp(0, 1'b1, k + LAT);
        @(negedge clk);
        bus.req = '0;
        for (int c = k + 1; c <= k + LAT + 1; c++) begin
            wait_cyc(c);
            check_eq("t1_ota_en", 32'(bus.ota_en), 32'(c <= k + LAT - 1));
            check_eq("t1_busy", 32'(bus.busy), 32'(c <= k + LAT));
            if (c != k + LAT) check_eq("t1_ack_low", 32'(bus.ack), 32'd0);
        end
        drain(50);
        check_eq("t1_hold_res_bit", 32'(bus.res_bit), 32'd1);
        check_eq("t1_hold_res_id", 32'(bus.res_id), 32'd0);

        // All four requesting from reset: order 0,1,2,3,0 with fixed spacing.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        k = cyc;
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) push_exp(n % 4, 1'b1, k + LAT + n * GAP);
        for (int n = 0; n < 5; n++) begin
            for (int j = 1; j <= SETTLE; j++) begin
                wait_cyc(k + n * GAP + j);
                check_eq("t2_mux_sel", 32'(bus.mux_sel), 32'(n % 4));
                check_eq("t2_ota_en", 32'(bus.ota_en), 32'd1);
                if (n == 4 && j == 1) bus.req = '0;
            end
        end
        drain(100);

        // Requester 2; comparator rises at SETTLE midpoint.
        bus.cmp_in = 1'b0;
        repeat (3) @(negedge clk);
        k = cyc;
        bus.req = 4'b0100;
        push_exp(2, 1'b1, k + LAT);
        @(negedge clk);
        bus.req = '0;
        wait_cyc(k + SETTLE / 2);
        bus.cmp_in = 1'b1;
        drain(50);

        // Comparator changes only in the last SETTLE cycle: too late for the synchroniser.
        k = cyc;
        bus.req = 4'b0100;
        push_exp(2, 1'(LATE_EXP), k + LAT);
        @(negedge clk);
        bus.req = '0;
        wait_cyc(k + SETTLE);
        bus.cmp_in = 1'b0;
        drain(50);

        // Requester 1 drops its request mid-SETTLE; the transaction still completes.
        repeat (3) @(negedge clk);
        k = cyc;
        bus.req = 4'b0010;
        push_exp(1, 1'b0, k + LAT);
        wait_cyc(k + 3);
        bus.req = '0;
        drain(50);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t4_no_regrant", 32'(bus.busy), 32'd0);
        end

`ifdef OTA_SCHED_VOTE_EN
        // Synchronised comparator reads 1,0,1 across the three SAMPLE cycles.
        k = cyc;
        bus.req = 4'b1000;
        push_exp(3, 1'b1, k + LAT);
        @(negedge clk);
        bus.req = '0;
        wait_cyc(k + SETTLE - 1);
        bus.cmp_in = 1'b1;
        wait_cyc(k + SETTLE);
        bus.cmp_in = 1'b0;
        wait_cyc(k + SETTLE + 1);
        bus.cmp_in = 1'b1;
        drain(50);
`endif

        // Reset during SAMPLE clears outputs without a clock edge; no ack follows.
        k = cyc;
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = '0;
        wait_cyc(k + SETTLE + 1);
        check_eq("t5_pre_ota_en", 32'(bus.ota_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t5_async_ota_en", 32'(bus.ota_en), 32'd0);
        check_eq("t5_async_busy", 32'(bus.busy), 32'd0);
        check_eq("t5_async_ack", 32'(bus.ack), 32'd0);
        check_eq("t5_async_mux_sel", 32'(bus.mux_sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.cmp_in = 1'b1;
        repeat (3) @(negedge clk);
        k = cyc;
        bus.req = 4'b0011;
        push_exp(0, 1'b1, k + LAT);
        push_exp(1, 1'b1, k + LAT + GAP);
        wait_cyc(k + GAP + 1);
        bus.req = '0;
        drain(100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
